beep_sched: RTL and testbench

Arbiter and sequencer for the board's single active-low buzzer. Shares the buzzer between three requesters:
- the time-limit countdown beeper (level, passthrough);
- the fall/penalty chirp (pulse request);
- the win fanfare (pulse request).

Timing comes from the 1/8-second phase counter (remainder) already distributed in the top level. Sits between the countdown beeper, the game-state logic and the buzzer pin.

---
 rtl/beep_sched_pkg.sv | 29 ++
 rtl/beep_sched_tick_detect.sv | 31 +++
 rtl/beep_sched.sv | 162 ++++++++++++++++
 tb/tb_beep_sched.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/beep_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : beep_sched_pkg
//  Purpose  : Shared definitions for the buzzer sequencer: state encodings,
//             owner codes and a small state-class helper.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package beep_sched_pkg;

  typedef enum logic [2:0] {
    BS_IDLE     = 3'd0,
    BS_FALL     = 3'd1,
    BS_WIN_ON   = 3'd2,
    BS_WIN_OFF  = 3'd3,
    BS_WIN_TAIL = 3'd4
  } bs_state_t;

  localparam logic [1:0] OWN_CD   = 2'd0;
  localparam logic [1:0] OWN_FALL = 2'd1;
  localparam logic [1:0] OWN_WIN  = 2'd2;

  // True for any state belonging to the win fanfare.
  function automatic logic is_win(input bs_state_t s);
    return (s == BS_WIN_ON) || (s == BS_WIN_OFF) || (s == BS_WIN_TAIL);
  endfunction

endpackage
`default_nettype wire

// File: rtl/beep_sched_tick_detect.sv
`default_nettype none
// ============================================================================
//  Module   : tick_detect
//  Purpose  : Turns the 1/8-second phase counter into a one-clk tick. Any
//             change of the phase (single step, wrap, or multi-step jump)
//             yields exactly one tick.
//  Ports    : clk        system clock
//             rst        asynchronous reset, active low
//             remainder  1/8-second phase input
//             tick       high for one clk when remainder differs from the
//                        copy registered on the previous clk
//  Revision : 1.0  initial release
// ============================================================================
module tick_detect (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] remainder,
  output logic       tick
);

  logic [2:0] remainder_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) remainder_q <= 3'd0;
    else      remainder_q <= remainder;
  end

  assign tick = (remainder != remainder_q);

endmodule
`default_nettype wire

// File: rtl/beep_sched.sv
`default_nettype none
// ============================================================================
//  Module   : beep_sched
//  Purpose  : Arbitrates the single active-low buzzer between the countdown
//             beeper (level passthrough), the fall chirp and the win fanfare.
//             The win fanfare preempts a fall chirp; the fanfare itself is
//             never interrupted.
//  Ports    : clk        system clock
//             rst        asynchronous reset, active low
//             remainder  1/8-second phase; each change is one tick
//             cd_beep_n  countdown beeper request (active low, level)
//             req_fall   one-clk pulse: play fall chirp
//             req_win    one-clk pulse: play win fanfare
//             mute       forces buzzer silent, sequencing continues
//             beep       buzzer drive (active low, registered)
//             busy       a chirp or fanfare is in progress
//             owner      0 countdown/idle, 1 fall, 2 win
//             done       one-clk pulse when a sequence completes normally
//  Revision : 1.0  initial release
// ============================================================================
module beep_sched
  import beep_sched_pkg::*;
#(
  parameter int FALL_LEN  = 2,
  parameter int NOTE_LEN  = 1,
  parameter int WIN_NOTES = 3,
  parameter int TAIL_LEN  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] remainder,
  input  logic       cd_beep_n,
  input  logic       req_fall,
  input  logic       req_win,
  input  logic       mute,
  output logic       beep,
  output logic       busy,
  output logic [1:0] owner,
  output logic       done
);

  // A state of length N leaves on the tick that finds tick_cnt at N-1.
  localparam logic [3:0] FALL_LAST  = 4'(FALL_LEN - 1);
  localparam logic [3:0] NOTE_LAST  = 4'(NOTE_LEN - 1);
  localparam logic [3:0] TAIL_LAST  = 4'(TAIL_LEN - 1);
  localparam logic [3:0] NOTES_LAST = 4'(WIN_NOTES - 1);

  bs_state_t  state, state_nx;
  logic [3:0] tick_cnt;
  logic [3:0] note_cnt, note_cnt_nx;
  logic       pend_fall, pend_fall_nx;
  logic       pend_win, pend_win_nx;
  logic       beep_nx, done_nx;
  logic       tick;

  tick_detect u_tick_detect (
    .clk       (clk),
    .rst       (rst),
    .remainder (remainder),
    .tick      (tick)
  );

  always_comb begin
    state_nx    = state;
    note_cnt_nx = note_cnt;
    done_nx     = 1'b0;
    // Requests are latched first; state transitions below may clear them.
    pend_win_nx  = pend_win  | (req_win  & ~is_win(state));
    pend_fall_nx = pend_fall | (req_fall & ((state == BS_IDLE) || (state == BS_FALL)));

    case (state)
      BS_IDLE: begin
        if (pend_win) begin
          state_nx     = BS_WIN_ON;
          note_cnt_nx  = 4'd0;
          pend_win_nx  = 1'b0;
          pend_fall_nx = 1'b0;
        end else if (pend_fall) begin
          state_nx     = BS_FALL;
          // A fresh req_fall in the same clk re-arms for a replay.
          pend_fall_nx = req_fall;
        end
      end
      BS_FALL: begin
        if (pend_win) begin
          // Preemption: the chirp and any re-armed chirp are dropped.
          state_nx     = BS_WIN_ON;
          note_cnt_nx  = 4'd0;
          pend_win_nx  = 1'b0;
          pend_fall_nx = 1'b0;
        end else if (tick && (tick_cnt == FALL_LAST)) begin
          state_nx = BS_IDLE;
          done_nx  = 1'b1;
        end
      end
      BS_WIN_ON: begin
        if (tick && (tick_cnt == NOTE_LAST)) state_nx = BS_WIN_OFF;
      end
      BS_WIN_OFF: begin
        if (tick && (tick_cnt == NOTE_LAST)) begin
          if (note_cnt == NOTES_LAST) begin
            state_nx = BS_WIN_TAIL;
          end else begin
            state_nx    = BS_WIN_ON;
            note_cnt_nx = note_cnt + 4'd1;
          end
        end
      end
      BS_WIN_TAIL: begin
        if (tick && (tick_cnt == TAIL_LAST)) begin
          state_nx = BS_IDLE;
          done_nx  = 1'b1;
        end
      end
      default: state_nx = BS_IDLE;
    endcase

    // Output is decided from the current state, so beep lags it by one clk.
    if (mute) begin
      beep_nx = 1'b1;
    end else begin
      case (state)
        BS_IDLE:                         beep_nx = cd_beep_n;
        BS_FALL, BS_WIN_ON, BS_WIN_TAIL: beep_nx = 1'b0;
        default:                         beep_nx = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= BS_IDLE;
      tick_cnt  <= 4'd0;
      note_cnt  <= 4'd0;
      pend_fall <= 1'b0;
      pend_win  <= 1'b0;
      beep      <= 1'b1;
      done      <= 1'b0;
    end else begin
      state     <= state_nx;
      note_cnt  <= note_cnt_nx;
      pend_fall <= pend_fall_nx;
      pend_win  <= pend_win_nx;
      beep      <= beep_nx;
      done      <= done_nx;
      if (state_nx != state) tick_cnt <= 4'd0;
      else if (tick)         tick_cnt <= tick_cnt + 4'd1;
    end
  end

  assign busy = (state != BS_IDLE);

  always_comb begin
    case (state)
      BS_FALL:                            owner = OWN_FALL;
      BS_WIN_ON, BS_WIN_OFF, BS_WIN_TAIL: owner = OWN_WIN;
      default:                            owner = OWN_CD;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_beep_sched.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_beep_sched
//  Purpose  : Self-checking bench for beep_sched. A segment-list reference
//             model (each sequence is a queue of on/off phases measured in
//             ticks) predicts beep/busy/owner/done every clk.
//  Revision : 1.0  initial release
// ============================================================================
module tb_beep_sched;

  localparam int FALL_LEN  = 2;
  localparam int NOTE_LEN  = 1;
  localparam int WIN_NOTES = 3;
  localparam int TAIL_LEN  = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] remainder = 3'd0;
  logic       cd_beep_n = 1'b1;
  logic       req_fall = 1'b0;
  logic       req_win = 1'b0;
  logic       mute = 1'b0;
  logic       beep, busy, done;
  logic [1:0] owner;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int rem_rand = 0;

  always #5 clk = ~clk;

  beep_sched #(
    .FALL_LEN (FALL_LEN),
    .NOTE_LEN (NOTE_LEN),
    .WIN_NOTES(WIN_NOTES),
    .TAIL_LEN (TAIL_LEN)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .remainder(remainder),
    .cd_beep_n(cd_beep_n),
    .req_fall (req_fall),
    .req_win  (req_win),
    .mute     (mute),
    .beep     (beep),
    .busy     (busy),
    .owner    (owner),
    .done     (done)
  );

  // Phase counter: advances every 4 clk; in random mode it may jump 1..3.
  initial forever begin
    @(posedge clk);
    cyc++;
    if (cyc % 4 == 0) begin
      #1;
      remainder = remainder + (rem_rand != 0 ? 3'($urandom_range(1, 3)) : 3'd1);
    end
  end

  // ---------------- reference model ----------------
  typedef struct { bit on; int len; } seg_t;
  seg_t       segs[$];
  int         m_owner = 0;
  int         m_ticks = 0;
  bit         m_pf = 0, m_pw = 0;
  logic [2:0] m_rq = 3'd0;
  logic       e_beep = 1'b1;
  logic       e_done = 1'b0;
  bit         tk, st_win, st_fall, nf, nw;
  int         old;

  initial forever begin
    @(posedge clk or negedge rst);
    if (!rst) begin
      segs.delete();
      m_owner = 0; m_ticks = 0; m_pf = 0; m_pw = 0; m_rq = 3'd0;
      e_beep = 1'b1; e_done = 1'b0;
    end else if (clk) begin
      old     = m_owner;
      tk      = (remainder != m_rq);
      e_beep  = mute ? 1'b1 : (old == 0 ? cd_beep_n : !segs[0].on);
      e_done  = 1'b0;
      st_win  = (old != 2) && m_pw;
      st_fall = (old == 0) && !m_pw && m_pf;
      nw = st_win ? 1'b0 : (m_pw | (req_win && old != 2));
      nf = st_win ? 1'b0 : ((st_fall ? 1'b0 : m_pf) | (req_fall && old != 2));
      if (st_win) begin
        segs.delete();
        for (int i = 0; i < WIN_NOTES; i++) begin
          segs.push_back('{1'b1, NOTE_LEN});
          segs.push_back('{1'b0, NOTE_LEN});
        end
        segs.push_back('{1'b1, TAIL_LEN});
        m_owner = 2; m_ticks = 0;
      end else if (st_fall) begin
        segs.delete();
        segs.push_back('{1'b1, FALL_LEN});
        m_owner = 1; m_ticks = 0;
      end else if (old != 0 && tk) begin
        m_ticks++;
        if (m_ticks == segs[0].len) begin
          void'(segs.pop_front());
          m_ticks = 0;
          if (segs.size() == 0) begin
            m_owner = 0;
            e_done  = 1'b1;
          end
        end
      end
      m_pw = nw; m_pf = nf; m_rq = remainder;
    end
  end

  // ---------------- scenarios ----------------
  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({beep, busy, owner, done} !== 5'b1_0_00_0)
      $display("FAIL reset_state got=%b want=10000", {beep, busy, owner, done});
    else n_pass++;
    @(posedge clk); #1 rst = 1'b1;
  endtask

  task automatic test_idle_passthrough();
    logic cd_prev = cd_beep_n;
    int   n_done = 0;
    for (int i = 0; i < 24; i++) begin
      @(posedge clk); #1;
      cd_beep_n = (i >= 4 && i < 9) || (i >= 14 && i < 15) ? 1'b0 : 1'b1;
      @(negedge clk);
      n_checks++;
      if ({beep, busy, owner, done} !== {e_beep, m_owner != 0, 2'(m_owner), e_done})
        $display("FAIL idle_model i=%0d got=%b want=%b", i, {beep, busy, owner, done},
                 {e_beep, m_owner != 0, 2'(m_owner), e_done});
      else n_pass++;
      n_checks++;
      if (beep !== cd_prev || busy !== 1'b0 || owner !== 2'd0)
        $display("FAIL idle_follow i=%0d beep=%b want=%b busy=%b owner=%0d", i, beep, cd_prev, busy, owner);
      else n_pass++;
      if (done === 1'b1) n_done++;
      cd_prev = cd_beep_n;
    end
    n_checks++;
    if (n_done !== 0) $display("FAIL idle_done count=%0d want=0", n_done);
    else n_pass++;
  endtask

  task automatic test_fall();
    int n_low = 0, n_done = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      req_fall = (i == 0);
      @(negedge clk);
      n_checks++;
      if ({beep, busy, owner, done} !== {e_beep, m_owner != 0, 2'(m_owner), e_done})
        $display("FAIL fall_model i=%0d got=%b want=%b", i, {beep, busy, owner, done},
                 {e_beep, m_owner != 0, 2'(m_owner), e_done});
      else n_pass++;
      if (beep === 1'b0) n_low++;
      if (done === 1'b1) n_done++;
    end
    n_checks++;
    if (n_low < 5 || n_low > 8) $display("FAIL fall_len low_clk=%0d want=5..8", n_low);
    else n_pass++;
    n_checks++;
    if (n_done !== 1 || owner !== 2'd0) $display("FAIL fall_done count=%0d owner=%0d want=1,0", n_done, owner);
    else n_pass++;
  endtask

  task automatic test_win(input bit mt, output int done_at);
    int   n_done = 0, n_fall_edges = 0, n_low = 0;
    logic bprev;
    done_at = -1;
    do @(negedge clk); while (cyc % 4 != 3);
    bprev = beep;
    for (int i = 0; i < 64; i++) begin
      @(posedge clk); #1;
      req_win   = (i == 0);
      mute      = mt;
      cd_beep_n = (i >= 2 && i < 56) ? 1'b0 : 1'b1;
      @(negedge clk);
      n_checks++;
      if ({beep, busy, owner, done} !== {e_beep, m_owner != 0, 2'(m_owner), e_done})
        $display("FAIL win_model mute=%0d i=%0d got=%b want=%b", mt, i, {beep, busy, owner, done},
                 {e_beep, m_owner != 0, 2'(m_owner), e_done});
      else n_pass++;
      if (done === 1'b1) begin n_done++; if (done_at < 0) done_at = i; end
      if (bprev === 1'b1 && beep === 1'b0) n_fall_edges++;
      if (beep === 1'b0) n_low++;
      bprev = beep;
    end
    mute = 1'b0;
    n_checks++;
    if (n_done !== 1) $display("FAIL win_done mute=%0d count=%0d want=1", mt, n_done);
    else n_pass++;
    n_checks++;
    if (mt ? (n_low !== 0) : (n_fall_edges !== WIN_NOTES + 1))
      $display("FAIL win_pattern mute=%0d edges=%0d low=%0d want_edges=%0d", mt, n_fall_edges, n_low, WIN_NOTES + 1);
    else n_pass++;
  endtask

  task automatic test_mute();
    int d0, d1;
    test_win(1'b0, d0);
    test_win(1'b1, d1);
    n_checks++;
    if (d0 < 0 || d1 !== d0) $display("FAIL mute_done_time got=%0d want=%0d", d1, d0);
    else n_pass++;
  endtask

  task automatic test_ignore_fall_in_win();
    int n_done = 0, n_fall_owner = 0;
    bit fired = 0;
    for (int i = 0; i < 90; i++) begin
      @(posedge clk); #1;
      req_win  = (i == 0);
      req_fall = 1'b0;
      if (!fired && m_owner == 2 && segs.size() > 0 && !segs[0].on) begin
        req_fall = 1'b1; fired = 1;
      end
      @(negedge clk);
      n_checks++;
      if ({beep, busy, owner, done} !== {e_beep, m_owner != 0, 2'(m_owner), e_done})
        $display("FAIL ignore_model i=%0d got=%b want=%b", i, {beep, busy, owner, done},
                 {e_beep, m_owner != 0, 2'(m_owner), e_done});
      else n_pass++;
      if (done === 1'b1) n_done++;
      if (owner === 2'd1) n_fall_owner++;
    end
    n_checks++;
    if (!fired || n_done !== 1 || n_fall_owner !== 0)
      $display("FAIL ignore_fall fired=%0d done=%0d fall_clk=%0d want=1,1,0", fired, n_done, n_fall_owner);
    else n_pass++;
  endtask

  task automatic test_preempt();
    int n_done = 0, first_win = -1;
    logic [1:0] own_at3 = 2'd3;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk); #1;
      req_fall = (i == 0);
      req_win  = (i == 3);
      @(negedge clk);
      n_checks++;
      if ({beep, busy, owner, done} !== {e_beep, m_owner != 0, 2'(m_owner), e_done})
        $display("FAIL preempt_model i=%0d got=%b want=%b", i, {beep, busy, owner, done},
                 {e_beep, m_owner != 0, 2'(m_owner), e_done});
      else n_pass++;
      if (i == 3) own_at3 = owner;
      if (owner === 2'd2 && first_win < 0) first_win = i;
      if (done === 1'b1) n_done++;
    end
    n_checks++;
    if (own_at3 !== 2'd1 || first_win < 4 || first_win > 5 || n_done !== 1)
      $display("FAIL preempt owner3=%0d first_win=%0d done=%0d want=1,4..5,1", own_at3, first_win, n_done);
    else n_pass++;
  endtask

  task automatic test_reset_mid_fall();
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      req_fall = (i == 0 || i == 5);
    end
    @(posedge clk); #1 req_fall = 1'b0;
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if ({beep, busy, owner} !== 4'b1_0_00)
      $display("FAIL reset_async got=%b want=1000", {beep, busy, owner});
    else n_pass++;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      cd_beep_n = (i >= 10 && i < 16) ? 1'b0 : 1'b1;
      @(negedge clk);
      n_checks++;
      if ({beep, busy, owner, done} !== {e_beep, m_owner != 0, 2'(m_owner), e_done}
          || busy !== 1'b0 || done !== 1'b0)
        $display("FAIL reset_resume i=%0d got=%b want=%b", i, {beep, busy, owner, done},
                 {e_beep, 1'b0, 2'd0, 1'b0});
      else n_pass++;
    end
  endtask

  task automatic test_random();
    rem_rand = 1;
    for (int i = 0; i < 1500; i++) begin
      @(posedge clk); #1;
      req_fall = ($urandom_range(0, 99) < 3);
      req_win  = ($urandom_range(0, 99) < 2);
      if ($urandom_range(0, 7) == 0) cd_beep_n = ~cd_beep_n;
      if ($urandom_range(0, 49) == 0) mute = ~mute;
      @(negedge clk);
      n_checks++;
      if ({beep, busy, owner, done} !== {e_beep, m_owner != 0, 2'(m_owner), e_done})
        $display("FAIL random_model i=%0d got=%b want=%b", i, {beep, busy, owner, done},
                 {e_beep, m_owner != 0, 2'(m_owner), e_done});
      else n_pass++;
    end
    rem_rand = 0;
    req_fall = 1'b0; req_win = 1'b0; mute = 1'b0; cd_beep_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_idle_passthrough();
    test_fall();
    test_mute();
    test_ignore_fall_in_win();
    test_preempt();
    test_reset_mid_fall();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
